adc_wave_src: RTL and testbench

- Synthesizable on-board test signal source for the oscilloscope front end.
- Drives the same 8-bit sample bus the scope core consumes from the ADC, so captures can be checked without external hardware.
- Produces sine, square, triangle or sawtooth from a phase accumulator, with amplitude scaling about mid-scale 0x80.
- Issues one sample every DIV clocks, together with an ADC-style sample clock.

---
 rtl/adc_wave_src.sv | 105 ++++++++++
 tb/tb_adc_wave_src.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_wave_src.sv
// adc_wave_src: on-board ADC-style test signal source (sine/square/triangle/sawtooth about mid-scale 0x80).
// Define ADC_WAVE_SINE_EN to compile in the sine LUT; without it wave_sel=0 produces triangle.
module adc_wave_src #(
    parameter int DIV     = 10,
    parameter int PHASE_W = 24
) (
    input  logic               clk_100m,
    input  logic               s,
    input  logic               run,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic [1:0]         wave_sel,
    input  logic [7:0]         amp,
    output logic [7:0]         ad_data,
    output logic               ad_valid,
    output logic               ad_clk
);
    localparam int CW = $clog2(DIV);

    logic [CW-1:0]      r_cnt;
    logic               r_ad_clk;
    logic [PHASE_W-1:0] r_acc;
    logic [7:0]         r_raw;
    logic [7:0]         r_amp;
    logic [7:0]         r_data;
    logic               r_v1;
    logic               r_valid;

    logic               w_tick;
    logic               w_emit;
    logic [CW-1:0]      w_cnt_nxt;
    logic [7:0]         w_p;
    logic [7:0]         w_tri;
    logic [7:0]         w_sq;
    logic [7:0]         w_sine;
    logic [7:0]         w_raw;
    logic [7:0]         w_scaled;
    logic [7:0]         w_out;
    logic signed [8:0]  w_d;
    logic signed [16:0] w_prod;

    assign w_tick    = r_cnt == CW'(DIV - 1);
    assign w_emit    = w_tick && run;
    assign w_cnt_nxt = w_tick ? '0 : r_cnt + 1'b1;
    assign w_p       = r_acc[PHASE_W-1 -: 8];
    assign w_tri     = w_p[7] ? {~w_p[6:0], 1'b0} : {w_p[6:0], 1'b0};
    assign w_sq      = w_p[7] ? 8'd0 : 8'd255;

`ifdef ADC_WAVE_SINE_EN
    // Quarter-wave table sampled at bin centres, so the wave never touches 0 or 128 exactly.
    localparam logic [6:0] SINE_LUT [64] = '{
        7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
        7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
        7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
        7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
        7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
        7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
        7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
    };
    logic [6:0] w_q;
    assign w_q    = SINE_LUT[w_p[6] ? ~w_p[5:0] : w_p[5:0]];
    assign w_sine = w_p[7] ? 8'd128 - {1'b0, w_q} : 8'd128 + {1'b0, w_q};
`else
    assign w_sine = w_tri;
`endif

    assign w_raw = (wave_sel == 2'd3) ? w_p :
                   (wave_sel == 2'd2) ? w_tri :
                   (wave_sel == 2'd1) ? w_sq : w_sine;

    // Signed scaling about mid-scale; >>> floors, so the result stays within 0..255.
    assign w_d      = $signed({1'b0, r_raw}) - 9'sd128;
    assign w_prod   = 17'(w_d) * 17'($signed({1'b0, r_amp}));
    assign w_scaled = 8'((w_prod >>> 8) + 17'sd128);
    assign w_out    = (r_amp == 8'hFF) ? r_raw : w_scaled;

    always_ff @(posedge clk_100m) begin
        if (!s) begin
            r_cnt    <= '0;
            r_ad_clk <= 1'b0;
            r_acc    <= '0;
            r_raw    <= 8'h80;
            r_amp    <= 8'hFF;
            r_v1     <= 1'b0;
            r_data   <= 8'h80;
            r_valid  <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_ad_clk <= w_cnt_nxt >= CW'(DIV / 2);
            r_v1     <= w_emit;
            r_valid  <= r_v1;
            if (w_emit) begin
                r_acc <= r_acc + freq_word;
                r_raw <= w_raw;
                r_amp <= amp;
            end
            if (r_v1)
                r_data <= w_out;
        end
    end

    assign ad_data  = r_data;
    assign ad_valid = r_valid;
    assign ad_clk   = r_ad_clk;
endmodule

// File: tb/tb_adc_wave_src.sv
// tb_adc_wave_src: vector table, directed sequences and randomized run against a cycle-level reference model.
// Honours ADC_WAVE_SINE_EN the same way the design does.
module tb_adc_wave_src;
    localparam int DIV = 10;
    localparam int PW  = 24;

    logic          clk = 1'b0;
    logic          s = 1'b0;
    logic          run = 1'b0;
    logic [PW-1:0] freq_word = '0;
    logic [1:0]    wave_sel = 2'd0;
    logic [7:0]    amp = 8'd255;
    logic [7:0]    ad_data;
    logic          ad_valid;
    logic          ad_clk;

    adc_wave_src #(.DIV(DIV), .PHASE_W(PW)) dut (
        .clk_100m (clk),
        .s        (s),
        .run      (run),
        .freq_word(freq_word),
        .wave_sel (wave_sel),
        .amp      (amp),
        .ad_data  (ad_data),
        .ad_valid (ad_valid),
        .ad_clk   (ad_clk)
    );

    always #5 clk = ~clk;

    typedef struct {int due; int val;} pend_t;
    typedef struct {int sel; int amp; int p; int exp;} vec_t;

    pend_t         pend[$];
    logic [PW-1:0] m_acc;
    int            m_data;
    int            k;
    int            nvalid;
    int            first_k;
    int            last;
    int            n_chk = 0;
    int            n_pass = 0;

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, got, got, exp, exp, k);
    endtask

    function automatic int model(input int p, input int sel, input int a);
        int raw;
        int i;
        int q;
        if (sel == 3) raw = p;
        else if (sel == 1) raw = (p < 128) ? 255 : 0;
`ifdef ADC_WAVE_SINE_EN
        else if (sel == 0) begin
            i = ((p % 128) < 64) ? p % 64 : 63 - p % 64;
            q = $rtoi(127.0 * $sin(3.141592653589793 * (i + 0.5) / 128.0) + 0.5);
            raw = (p < 128) ? 128 + q : 128 - q;
        end
`endif
        else raw = (p < 128) ? 2 * p : 2 * (255 - p);
        if (a == 255) return raw;
        return ($rtoi($floor(real'((raw - 128) * a) / 256.0)) + 128) % 256;
    endfunction

    // One clock: model the tick of the current cycle, advance, then compare every output.
    task automatic step();
        int exp_v;
        if ((k % DIV) == DIV - 1 && run) begin
            pend.push_back('{due: k + 2, val: model(int'(m_acc[PW-1 -: 8]), int'(wave_sel), int'(amp))});
            m_acc = m_acc + freq_word;
        end
        @(posedge clk);
        #1;
        k++;
        exp_v = 0;
        if (pend.size() > 0 && pend[0].due == k) begin
            exp_v = 1;
            m_data = pend[0].val;
            pend.delete(0);
        end
        check("cycle{clk,valid,data}", int'(ad_clk) * 512 + int'(ad_valid) * 256 + int'(ad_data),
              int'((k % DIV) >= DIV / 2) * 512 + exp_v * 256 + m_data);
        if (ad_valid) begin
            nvalid++;
            last = int'(ad_data);
            if (first_k < 0) first_k = k;
        end
    endtask

    task automatic do_reset();
        s = 1'b0;
        @(posedge clk);
        #1;
        check("rst_data", int'(ad_data), 128);
        check("rst_valid", int'(ad_valid), 0);
        check("rst_clk", int'(ad_clk), 0);
        s = 1'b1;
        k = 0;
        m_acc = '0;
        m_data = 128;
        pend.delete();
        nvalid = 0;
        first_k = -1;
        last = -1;
    endtask

    initial begin
        vec_t vec [20];
        int   prev_k;
        int   n0;
        int   mn;
        int   mx;
        vec[0]  = '{3, 255,   0,   0};
        vec[1]  = '{3, 255, 200, 200};
        vec[2]  = '{1, 255, 127, 255};
        vec[3]  = '{1, 255, 128,   0};
        vec[4]  = '{1, 128,  10, 191};
        vec[5]  = '{1, 128, 200,  64};
        vec[6]  = '{2, 255, 127, 254};
        vec[7]  = '{2, 255, 128, 254};
        vec[8]  = '{2, 255, 255,   0};
        vec[9]  = '{2,   0, 100, 128};
        vec[10] = '{3, 128,   0,  64};
        vec[11] = '{3, 254, 255, 254};
        vec[12] = '{3, 254,   0,   1};
        vec[13] = '{2, 100,  64, 128};
        vec[14] = '{3,   1,   0, 127};
        vec[15] = '{3,   1, 255, 128};
        vec[16] = '{2, 255,   1,   2};
`ifdef ADC_WAVE_SINE_EN
        vec[17] = '{0, 255,  64, 255};
        vec[18] = '{0, 255, 192,   1};
        vec[19] = '{0, 255,   0, 130};
`else
        vec[17] = '{0, 255,  64, 128};
        vec[18] = '{0, 255, 192, 126};
        vec[19] = '{0, 255,   0,   0};
`endif
        k = 0;
        do_reset();

        // Second sample of each run sits at phase p because freq_word = p << (PW-8).
        foreach (vec[i]) begin
            do_reset();
            run = 1'b1;
            wave_sel = 2'(vec[i].sel);
            amp = 8'(vec[i].amp);
            freq_word = PW'(vec[i].p) << (PW - 8);
            for (int c = 0; c < 40 && nvalid < 2; c++) step();
            check($sformatf("vec%0d_count", i), nvalid, 2);
            check($sformatf("vec%0d_data", i), last, vec[i].exp);
        end

        do_reset();
        run = 1'b1; wave_sel = 2'd3; amp = 8'd255; freq_word = PW'(1) << (PW - 8);
        prev_k = 0;
        for (int c = 0; c < 2700 && nvalid < 257; c++) begin
            step();
            if (ad_valid) begin
                check("ramp_data", int'(ad_data), (nvalid - 1) % 256);
                if (nvalid > 1) check("ramp_period", k - prev_k, DIV);
                prev_k = k;
            end
        end
        check("ramp_first_k", first_k, 11);
        check("ramp_count", nvalid, 257);

        run = 1'b0;
        n0 = nvalid;
        repeat (50) step();
        check("hold_count", nvalid - n0, 0);
        check("hold_data", int'(ad_data), 0);
        run = 1'b1;
        for (int c = 0; c < 30 && nvalid == n0; c++) step();
        check("resume_data", last, 1);

        do_reset();
        run = 1'b1; wave_sel = 2'd1; amp = 8'd128; freq_word = PW'(1) << (PW - 8);
        step();
        check("sq_pre", int'(ad_data), 128);
        for (int c = 0; c < 2700 && nvalid < 256; c++) begin
            step();
            if (ad_valid) check("sq_data", int'(ad_data), (nvalid <= 128) ? 191 : 64);
        end
        check("sq_count", nvalid, 256);

        do_reset();
        run = 1'b1; wave_sel = 2'd2; amp = 8'd0; freq_word = PW'(11) << (PW - 8);
        for (int c = 0; c < 250 && nvalid < 20; c++) begin
            step();
            if (ad_valid) check("tri_amp0", int'(ad_data), 128);
        end

        do_reset();
        run = 1'b1; wave_sel = 2'd0; amp = 8'd255; freq_word = PW'(1) << (PW - 6);
        mn = 999; mx = -1;
        for (int c = 0; c < 700 && nvalid < 64; c++) begin
            step();
            if (ad_valid) begin
                mn = (last < mn) ? last : mn;
                mx = (last > mx) ? last : mx;
            end
        end
        check("wave0_count", nvalid, 64);
`ifdef ADC_WAVE_SINE_EN
        check("wave0_min", mn, 1);
        check("wave0_max", mx, 255);
`else
        check("wave0_min", mn, 0);
        check("wave0_max", mx, 254);
`endif

        do_reset();
        run = 1'b1; wave_sel = 2'd3; amp = 8'd255; freq_word = PW'(5) << (PW - 8);
        repeat (10) step();
        do_reset();
        for (int c = 0; c < 20 && nvalid < 1; c++) step();
        check("rst_restart_k", first_k, 11);
        check("rst_restart_data", last, 0);

        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            run = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0)
                freq_word = ($urandom_range(0, 1) == 1) ? PW'($urandom) : PW'($urandom_range(0, 255)) << (PW - 8);
            wave_sel = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: amp = 8'd255;
                1: amp = 8'd0;
                default: amp = 8'($urandom_range(0, 255));
            endcase
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
